passcode_checker: RTL and testbench

//  Collects four keypad digits, compares them against a stored 4-digit BCD code and drives the

---
 rtl/passcode_pkg.sv | 32 +++
 rtl/state_timer.sv | 27 ++
 rtl/passcode_checker.sv | 151 +++++++++++++++
 tb/tb_passcode_checker.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/passcode_pkg.sv
// Shared passcode types and helpers.
// Used by the checker, keypad and display blocks.
package passcode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        UNLOCKED,
        LOCKOUT
    } state_t;

    function automatic int ms_to_cycles(
        input int ms,
        input int clk_hz
    );
        longint prod;
        prod = longint'(ms) * longint'(clk_hz);
        return int'(prod / longint'(1000));
    endfunction

    function automatic int max3(
        input int a,
        input int b,
        input int c
    );
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/state_timer.sv
// Loadable down-counter that saturates at zero.
// done stays high while the count is zero.
module state_timer #(
    parameter int W = 8
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/passcode_checker.sv
// Four-digit keypad passcode checker with
// unlock window, entry timeout and lockout.
module passcode_checker #(
    parameter int          CLK_HZ     = 25_000_000,
    parameter logic [15:0] CODE       = 16'h1234,
    parameter int          UNLOCK_MS  = 5000,
    parameter int          ENTRY_MS   = 10000,
    parameter int          LOCKOUT_MS = 30000,
    parameter int          MAX_TRIES  = 3
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Digit_Valid,
    input  logic [3:0] i_Digit,
    input  logic       i_Clear,
    output logic       o_Answer,
    output logic       o_Fail,
    output logic       o_Lockout,
    output logic [2:0] o_Digit_Count
);

    import passcode_pkg::*;

    localparam int UNLOCK_CYC = ms_to_cycles(UNLOCK_MS, CLK_HZ);
    localparam int ENTRY_CYC = ms_to_cycles(ENTRY_MS, CLK_HZ);
    localparam int LOCK_CYC = ms_to_cycles(LOCKOUT_MS, CLK_HZ);
    localparam int MAX_CYC = max3(UNLOCK_CYC, ENTRY_CYC, LOCK_CYC);
    localparam int TW = $clog2(MAX_CYC + 1);

    // The load cycle itself counts, so windows load one less.
    localparam logic [TW-1:0] UNLOCK_LD = TW'(UNLOCK_CYC - 1);
    localparam logic [TW-1:0] ENTRY_LD = TW'(ENTRY_CYC - 1);
    localparam logic [TW-1:0] LOCK_LD = TW'(LOCK_CYC - 1);
    localparam logic [2:0] TRIES = 3'(MAX_TRIES);

    state_t state, state_n;
    logic [15:0] shift, shift_n;
    logic [2:0] fails, fails_n;
    logic [2:0] count_n;
    logic fail_n;
    logic digit_ok;
    logic take;
    logic tmr_load;
    logic [TW-1:0] tmr_value;
    logic tmr_done;

    state_timer #(
        .W(TW)
    ) u_timer (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .load      (tmr_load),
        .load_value(tmr_value),
        .done      (tmr_done)
    );

    assign digit_ok = i_Digit_Valid && !i_Clear
                      && (i_Digit <= 4'd9);

    always_comb begin
        state_n = state;
        shift_n = shift;
        fails_n = fails;
        count_n = o_Digit_Count;
        fail_n = 1'b0;
        take = 1'b0;
        unique case (state)
            IDLE: begin
                if (digit_ok) begin
                    take = 1'b1;
                    state_n = ENTRY;
                    count_n = 3'd1;
                    shift_n = {shift[11:0], i_Digit};
                end
            end
            ENTRY: begin
                if (i_Clear) begin
                    state_n = IDLE;
                end else if (digit_ok) begin
                    take = 1'b1;
                    count_n = o_Digit_Count + 3'd1;
                    shift_n = {shift[11:0], i_Digit};
                    if (o_Digit_Count == 3'd3) begin
                        state_n = CHECK;
                    end
                end else if (tmr_done) begin
                    state_n = IDLE;
                end
            end
            CHECK: begin
                if (shift == CODE) begin
                    state_n = UNLOCKED;
                    fails_n = 3'd0;
                end else begin
                    fail_n = 1'b1;
                    fails_n = fails + 3'd1;
                    if (fails + 3'd1 == TRIES) begin
                        state_n = LOCKOUT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            UNLOCKED: begin
                if (tmr_done) begin
                    state_n = IDLE;
                end
            end
            LOCKOUT: begin
                if (tmr_done) begin
                    state_n = IDLE;
                    fails_n = 3'd0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (state_n != ENTRY) begin
            count_n = 3'd0;
        end
        tmr_load = take || (state_n != state);
        unique case (state_n)
            ENTRY:    tmr_value = ENTRY_LD;
            UNLOCKED: tmr_value = UNLOCK_LD;
            LOCKOUT:  tmr_value = LOCK_LD;
            default:  tmr_value = '0;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= IDLE;
            shift <= '0;
            fails <= '0;
            o_Digit_Count <= '0;
            o_Answer <= 1'b0;
            o_Fail <= 1'b0;
            o_Lockout <= 1'b0;
        end else begin
            state <= state_n;
            shift <= shift_n;
            fails <= fails_n;
            o_Digit_Count <= count_n;
            o_Answer <= (state_n == UNLOCKED);
            o_Fail <= fail_n;
            o_Lockout <= (state_n == LOCKOUT);
        end
    end

endmodule

// File: tb/tb_passcode_checker.sv
// Directed bench for passcode_checker with a
// cycle-level reference model and literal checks.
module tb_passcode_checker;

    localparam int CLK_HZ = 1000;
    localparam int UNLOCK_MS = 20;
    localparam int ENTRY_MS = 10;
    localparam int LOCKOUT_MS = 50;
    localparam int MAX_TRIES = 3;
    localparam int CODE_INT = 'h1234;

    logic       i_Clk;
    logic       i_Rst;
    logic       i_Digit_Valid;
    logic [3:0] i_Digit;
    logic       i_Clear;
    logic       o_Answer;
    logic       o_Fail;
    logic       o_Lockout;
    logic [2:0] o_Digit_Count;

    int n_checks = 0;
    int n_fail = 0;

    passcode_checker #(
        .CLK_HZ    (CLK_HZ),
        .CODE      (16'h1234),
        .UNLOCK_MS (UNLOCK_MS),
        .ENTRY_MS  (ENTRY_MS),
        .LOCKOUT_MS(LOCKOUT_MS),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_Digit_Valid(i_Digit_Valid),
        .i_Digit      (i_Digit),
        .i_Clear      (i_Clear),
        .o_Answer     (o_Answer),
        .o_Fail       (o_Fail),
        .o_Lockout    (o_Lockout),
        .o_Digit_Count(o_Digit_Count)
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: spec-level bookkeeping of the entry,
    // remaining window lengths and consecutive failures.
    int  m_entry[$];
    int  m_quiet = 0;
    int  m_unlock = 0;
    int  m_lock = 0;
    int  m_fails = 0;
    bit  m_pending = 0;
    bit  m_failp = 0;
    bit  m_valid = 0;

    task automatic model_step();
        int code;
        m_failp = 0;
        if (i_Rst) begin
            m_entry.delete();
            m_quiet = 0;
            m_unlock = 0;
            m_lock = 0;
            m_fails = 0;
            m_pending = 0;
        end else if (m_pending) begin
            code = m_entry[0] * 4096 + m_entry[1] * 256
                   + m_entry[2] * 16 + m_entry[3];
            m_entry.delete();
            m_pending = 0;
            if (code == CODE_INT) begin
                m_unlock = UNLOCK_MS;
                m_fails = 0;
            end else begin
                m_failp = 1;
                m_fails++;
                if (m_fails == MAX_TRIES) m_lock = LOCKOUT_MS;
            end
        end else if (m_unlock > 0) begin
            m_unlock--;
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fails = 0;
        end else if (i_Clear) begin
            m_entry.delete();
        end else if (i_Digit_Valid && i_Digit <= 4'd9) begin
            m_entry.push_back(int'(i_Digit));
            m_quiet = 0;
            if (m_entry.size() == 4) m_pending = 1;
        end else if (m_entry.size() > 0) begin
            m_quiet++;
            if (m_quiet == ENTRY_MS) m_entry.delete();
        end
        m_valid = 1;
    endtask

    initial begin
        forever begin
            @(posedge i_Clk);
            model_step();
        end
    end

    int fail_seen = 0;
    int ans_run = 0;
    int ans_len = 0;
    int lock_run = 0;
    int lock_len = 0;

    initial begin
        forever begin
            @(negedge i_Clk);
            if (m_valid) begin
                chk("cyc_answer", 32'(o_Answer), 32'(m_unlock > 0));
                chk("cyc_lockout", 32'(o_Lockout), 32'(m_lock > 0));
                chk("cyc_fail", 32'(o_Fail), 32'(m_failp));
                chk("cyc_count", 32'(o_Digit_Count),
                    m_pending ? 32'd0 : 32'(m_entry.size()));
                if (o_Fail === 1'b1) fail_seen++;
                if (o_Answer === 1'b1) begin
                    ans_run++;
                end else begin
                    if (ans_run > 0) ans_len = ans_run;
                    ans_run = 0;
                end
                if (o_Lockout === 1'b1) begin
                    lock_run++;
                end else begin
                    if (lock_run > 0) lock_len = lock_run;
                    lock_run = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic key(input int d);
        i_Digit = 4'(d);
        i_Digit_Valid = 1'b1;
        tick();
        i_Digit_Valid = 1'b0;
    endtask

    task automatic enter(input int a, input int b,
                         input int c, input int d);
        key(a);
        key(b);
        key(c);
        key(d);
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((o_Answer || o_Lockout) && n < 80) begin
            tick();
            n++;
        end
        chk(name, 32'(o_Answer | o_Lockout), 32'd0);
        tick();
    endtask

    initial begin
        i_Rst = 1'b1;
        i_Digit_Valid = 1'b0;
        i_Digit = 4'd0;
        i_Clear = 1'b0;
        ticks(3);
        chk("rst_answer", 32'(o_Answer), 32'd0);
        chk("rst_fail", 32'(o_Fail), 32'd0);
        chk("rst_lockout", 32'(o_Lockout), 32'd0);
        chk("rst_count", 32'(o_Digit_Count), 32'd0);
        i_Rst = 1'b0;
        tick();

        key(1);
        key(2);
        chk("count_two", 32'(o_Digit_Count), 32'd2);
        key(3);
        key(4);
        chk("check_cycle_answer", 32'(o_Answer), 32'd0);
        chk("check_cycle_count", 32'(o_Digit_Count), 32'd0);
        tick();
        chk("unlock_latency", 32'(o_Answer), 32'd1);
        wait_idle("unlock_end");
        chk("unlock_len", 32'(ans_len), 32'd20);
        chk("no_fail_on_good", 32'(fail_seen), 32'd0);

        enter(1, 2, 3, 5);
        chk("wrong1_fail", 32'(o_Fail), 32'd1);
        enter(1, 2, 3, 5);
        enter(1, 2, 3, 5);
        chk("wrong3_fail", 32'(o_Fail), 32'd1);
        chk("wrong3_lockout", 32'(o_Lockout), 32'd1);
        tick();
        chk("fail_pulses", 32'(fail_seen), 32'd3);
        enter(1, 2, 3, 4);
        chk("lock_ignores", 32'(o_Answer), 32'd0);
        wait_idle("lock_end");
        chk("lock_len", 32'(lock_len), 32'd50);
        enter(1, 2, 3, 4);
        chk("unlock_after_lock", 32'(o_Answer), 32'd1);
        wait_idle("unlock_end2");

        enter(1, 2, 3, 5);
        enter(1, 2, 3, 4);
        chk("good_mid", 32'(o_Answer), 32'd1);
        wait_idle("unlock_end3");
        enter(1, 2, 3, 5);
        enter(1, 2, 3, 5);
        chk("no_lockout", 32'(o_Lockout), 32'd0);
        tick();
        chk("fail_pulses2", 32'(fail_seen), 32'd6);

        key(1);
        key(2);
        ticks(9);
        chk("before_timeout", 32'(o_Digit_Count), 32'd2);
        tick();
        chk("after_timeout", 32'(o_Digit_Count), 32'd0);
        chk("timeout_no_fail", 32'(fail_seen), 32'd6);
        enter(1, 2, 3, 4);
        chk("unlock_after_to", 32'(o_Answer), 32'd1);
        wait_idle("unlock_end4");

        key(1);
        key(2);
        i_Clear = 1'b1;
        key(3);
        i_Clear = 1'b0;
        chk("clear_wins", 32'(o_Digit_Count), 32'd0);
        key(1);
        key(12);
        chk("digit12_ignored", 32'(o_Digit_Count), 32'd1);
        i_Clear = 1'b1;
        tick();
        i_Clear = 1'b0;
        chk("clear_count", 32'(o_Digit_Count), 32'd0);

        enter(1, 2, 3, 4);
        ticks(5);
        i_Rst = 1'b1;
        tick();
        chk("rst_unlock_ans", 32'(o_Answer), 32'd0);
        chk("rst_unlock_cnt", 32'(o_Digit_Count), 32'd0);
        i_Rst = 1'b0;
        tick();
        enter(1, 2, 3, 5);
        enter(1, 2, 3, 5);
        enter(1, 2, 3, 5);
        chk("lock_again", 32'(o_Lockout), 32'd1);
        ticks(10);
        i_Rst = 1'b1;
        tick();
        chk("rst_lock_lock", 32'(o_Lockout), 32'd0);
        chk("rst_lock_fail", 32'(o_Fail), 32'd0);
        chk("rst_lock_ans", 32'(o_Answer), 32'd0);
        i_Rst = 1'b0;
        tick();
        enter(1, 2, 3, 4);
        chk("unlock_after_rst", 32'(o_Answer), 32'd1);
        ticks(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
